// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

    localparam int PAT_W_MAX = 32;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    // Increment val unless it already sits at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [32:0] lim;
        lim = (33'd1 << width) - 33'd1;
        return ({1'b0, val} >= lim) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = W'(sat_inc(32'(cnt_q), W));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector: runtime-loadable pattern, overlap select,
// registered one-cycle match pulse and saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W    = 3,
    parameter logic [PAT_W-1:0] PAT_INIT = 3'b101,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    localparam int               FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_n;
    logic [FILL_W-1:0] fill_q, fill_d, fill_n;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic              out_q, out_d;
    logic              hit;
    logic              cnt_clr;
    mode_e             mode;

    assign mode = mode_e'(overlap);

    // fill/hist together form the detector state: fill counts valid history bits.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        out_d     = 1'b0;
        hit       = 1'b0;
        hist_n    = {hist_q[PAT_W-2:0], a};
        fill_n    = (fill_q == FULL) ? fill_q : fill_q + FILL_W'(1);
        if (pat_load) begin
            pattern_d = pat_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hit    = (fill_n == FULL) && (hist_n == pattern_q);
            hist_d = hist_n;
            fill_d = fill_n;
            if (hit && mode == MODE_NONOVL) begin
                fill_d = '0;
            end
            out_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= PAT_INIT;
            out_q     <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            out_q     <= out_d;
        end
    end

    // A pattern load takes precedence over the counter clear.
    assign cnt_clr = clr_cnt && !pat_load;

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

    assign out     = out_q;
    assign pattern = pattern_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations driven in parallel and
// compared every cycle against a queue-based reference model.
module tb_seq_detect_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a = 1'b0;
    logic        in_valid = 1'b0;
    logic        overlap = 1'b0;
    logic        pat_load = 1'b0;
    logic [31:0] pat_in = '0;
    logic        clr_cnt = 1'b0;

    logic       out3, out4, outc;
    logic [7:0] cnt3, cnt4;
    logic [1:0] cntc;
    logic [2:0] pat3, patc;
    logic [3:0] pat4;

    always #5 clk = ~clk;

    seq_detect_param u_dut3 (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in[2:0]), .clr_cnt(clr_cnt),
        .out(out3), .match_cnt(cnt3), .pattern(pat3)
    );

    seq_detect_param #(.PAT_W(4), .PAT_INIT(4'b0110), .CNT_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in[3:0]), .clr_cnt(clr_cnt),
        .out(out4), .match_cnt(cnt4), .pattern(pat4)
    );

    seq_detect_param #(.PAT_W(3), .PAT_INIT(3'b101), .CNT_W(2)) u_dutc (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in[2:0]), .clr_cnt(clr_cnt),
        .out(outc), .match_cnt(cntc), .pattern(patc)
    );

    // Reference model: bits received since the last flush, oldest first.
    int  w[3]    = '{3, 4, 3};
    int  cmax[3] = '{255, 255, 3};
    int  init[3] = '{5, 6, 5};
    int  pat[3];
    int  cnt[3];
    bit  eout[3];
    bit  hq[3][$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out3", 32'(out3), 32'(eout[0]));
        check("cnt3", 32'(cnt3), 32'(cnt[0]));
        check("pat3", 32'(pat3), 32'(pat[0]));
        check("out4", 32'(out4), 32'(eout[1]));
        check("cnt4", 32'(cnt4), 32'(cnt[1]));
        check("pat4", 32'(pat4), 32'(pat[1]));
        check("outc", 32'(outc), 32'(eout[2]));
        check("cntc", 32'(cntc), 32'(cnt[2]));
        check("patc", 32'(patc), 32'(pat[2]));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            pat[d]  = init[d];
            cnt[d]  = 0;
            eout[d] = 1'b0;
            hq[d].delete();
        end
    endtask

    task automatic model_edge(input bit a_i, input bit v_i, input bit o_i,
                              input bit l_i, input logic [31:0] p_i, input bit c_i);
        for (int d = 0; d < 3; d++) begin
            eout[d] = 1'b0;
            if (l_i) begin
                pat[d] = int'(p_i) & ((1 << w[d]) - 1);
                hq[d].delete();
            end else begin
                bit hit = 1'b0;
                if (v_i) begin
                    int v = 0;
                    hq[d].push_back(a_i);
                    if (hq[d].size() > w[d]) void'(hq[d].pop_front());
                    for (int i = 0; i < hq[d].size(); i++) v = (v << 1) | int'(hq[d][i]);
                    hit = (hq[d].size() == w[d]) && (v == pat[d]);
                    if (hit && !o_i) hq[d].delete();
                end
                eout[d] = hit;
                if (c_i) cnt[d] = 0;
                else if (hit && cnt[d] < cmax[d]) cnt[d]++;
            end
        end
    endtask

    task automatic step(input bit a_i, input bit v_i, input bit o_i,
                        input bit l_i, input logic [31:0] p_i, input bit c_i);
        a = a_i; in_valid = v_i; overlap = o_i; pat_load = l_i; pat_in = p_i; clr_cnt = c_i;
        model_edge(a_i, v_i, o_i, l_i, p_i, c_i);
        @(posedge clk); #1;
        cyc++;
        check_all();
    endtask

    task automatic do_reset(input bit a_i, input bit v_i);
        reset = 1'b1; a = a_i; in_valid = v_i; overlap = 1'b1;
        pat_load = 1'b0; clr_cnt = 1'b0;
        model_reset();
        @(posedge clk); #1;
        cyc++;
        check_all();
        reset = 1'b0;
    endtask

    task automatic bits(input logic [31:0] v, input int n, input bit o_i);
        for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, o_i, 1'b0, '0, 1'b0);
    endtask

    initial begin
        // Reset state
        do_reset(1'b0, 1'b0);
        check("rst_pat3", 32'(pat3), 32'h5);
        check("rst_pat4", 32'(pat4), 32'h6);

        // Overlapping 1,0,1,0,1 on pattern 101
        bits(32'b10101, 5, 1'b1);
        check("t1_cnt", 32'(cnt3), 32'd2);

        // Non-overlapping
        do_reset(1'b0, 1'b0);
        bits(32'b10101, 5, 1'b0);
        check("t2_cnt", 32'(cnt3), 32'd1);

        // in_valid gaps
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        check("t4_pulse", 32'(out3), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("t4_single", 32'(out3), 32'd0);

        // Counter saturation at CNT_W=2, then clear on a hit edge
        do_reset(1'b0, 1'b0);
        bits(32'b10101010101, 11, 1'b1);
        check("t5_sat", 32'(cntc), 32'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        check("t5_clr_cnt", 32'(cntc), 32'd0);
        check("t5_clr_out", 32'(outc), 32'd1);

        // Reset mid-stream
        do_reset(1'b0, 1'b0);
        bits(32'b10, 2, 1'b1);
        do_reset(1'b1, 1'b1);
        check("t6_pat", 32'(pat3), 32'h5);
        check("t6_cnt", 32'(cnt3), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        check("t6_nopulse", 32'(out3), 32'd0);

        // Load 1100 with a same-edge valid bit, then stream
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
        check("t3_pat4", 32'(pat4), 32'hC);
        bits(32'b11001100, 8, 1'b1);
        check("t3_cnt4", 32'(cnt4), 32'd2);

        // Identity pattern, constant input
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        bits(32'hFF, 8, 1'b1);
        check("id_cnt4", 32'(cnt4), 32'd7);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1'($urandom), 1'($urandom));
            end else begin
                bit ld = ($urandom_range(0, 24) == 0);
                bit cl = !ld && ($urandom_range(0, 15) == 0);
                logic [31:0] p = ($urandom_range(0, 3) == 0) ? {32{1'($urandom)}} : $urandom;
                step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                     ld, p, cl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
